// File: rtl/gateway_rx_filter.sv
// RX-path capability filter: judges each packet on its SOP beat and forwards accepted packets through a one-deep output slice.
// Optional build macro GW_RX_STATS_EN adds saturating accept/drop packet counters.
module gateway_rx_filter #(
    parameter int DATA_BITS = 512,
    parameter int N_SRCS    = 4,
    parameter int ALLOW_EXT = 1
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   cfg_valid,
    input  logic [14:0]            cfg_data,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DATA_BITS-1:0]   s_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic [13:0]            s_axis_tuser,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [13:0]            m_axis_tdest,
    output logic                   drop_pulse
`ifdef GW_RX_STATS_EN
    ,
    output logic [31:0]            pkt_acc_cnt,
    output logic [31:0]            pkt_drop_cnt
`endif
);
    localparam int KEEP_BITS = DATA_BITS / 8;

    typedef enum logic [1:0] {ST_SOP, ST_PASS, ST_DROP} state_t;

    state_t                state_q, state_d;
    logic [5:0]            ident_q;
    logic [N_SRCS-1:0]     entry_en_q;
    logic [5:0]            entry_src_q [N_SRCS];
    logic [N_SRCS-1:0]     entry_hit;
    logic [13:0]           pkt_dest_q;

    logic                  m_valid_q;
    logic [DATA_BITS-1:0]  m_data_q;
    logic [KEEP_BITS-1:0]  m_keep_q;
    logic                  m_last_q;
    logic [13:0]           m_dest_q;

    logic [5:0]            rt_src;
    logic [5:0]            rt_dst;
    logic                  accept;
    logic                  in_ready;
    logic                  in_hs;
    logic                  sop_hs;
    logic                  fwd;
    logic                  unused_rsvd;

    assign rt_src      = s_axis_tuser[13:8];
    assign rt_dst      = s_axis_tuser[7:2];
    assign unused_rsvd = ^s_axis_tuser[1:0];

    // Table entries whose index lies outside N_SRCS simply match no slot.
    generate
        for (genvar gi = 0; gi < N_SRCS; gi++) begin : g_entry
            always_ff @(posedge aclk) begin
                if (areset) begin
                    entry_en_q[gi]  <= 1'b0;
                    entry_src_q[gi] <= 6'd0;
                end else if (cfg_valid && (cfg_data[1:0] == 2'(gi))) begin
                    entry_en_q[gi]  <= cfg_data[14];
                    entry_src_q[gi] <= cfg_data[7:2];
                end
            end
            assign entry_hit[gi] = entry_en_q[gi] && (entry_src_q[gi] == rt_src);
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (areset) begin
            ident_q <= 6'b01_0000;
        end else if (cfg_valid && (cfg_data[13:8] != 6'd0)) begin
            ident_q <= cfg_data[13:8];
        end
    end

    // Verdict uses registered table/identity, so a same-cycle config write only affects later packets.
    assign accept = (rt_dst == ident_q) && (rt_dst != 6'd0)
                 && (((ALLOW_EXT != 0) && (rt_src == 6'd0)) || (|entry_hit));

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_SOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SOP: begin
                if (sop_hs && !s_axis_tlast) begin
                    state_d = accept ? ST_PASS : ST_DROP;
                end
            end
            ST_PASS, ST_DROP: begin
                if (in_hs && s_axis_tlast) begin
                    state_d = ST_SOP;
                end
            end
            default: state_d = ST_SOP;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == ST_DROP) || !m_valid_q || m_axis_tready;
        in_hs      = s_axis_tvalid && in_ready;
        sop_hs     = in_hs && (state_q == ST_SOP);
        fwd        = in_hs && ((state_q == ST_PASS) || ((state_q == ST_SOP) && accept));
        drop_pulse = sop_hs && !accept && !areset;
    end

    assign s_axis_tready = in_ready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_dest_q <= 14'd0;
        end else if (sop_hs && accept) begin
            pkt_dest_q <= s_axis_tuser;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            m_dest_q  <= 14'd0;
        end else if (fwd) begin
            m_valid_q <= 1'b1;
            m_data_q  <= s_axis_tdata;
            m_keep_q  <= s_axis_tkeep;
            m_last_q  <= s_axis_tlast;
            m_dest_q  <= (state_q == ST_SOP) ? s_axis_tuser : pkt_dest_q;
        end else if (m_axis_tready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tdest  = m_dest_q;

`ifdef GW_RX_STATS_EN
    logic [31:0] acc_cnt_q;
    logic [31:0] drop_cnt_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_cnt_q  <= 32'd0;
            drop_cnt_q <= 32'd0;
        end else if (sop_hs) begin
            if (accept && (acc_cnt_q != 32'hFFFF_FFFF)) begin
                acc_cnt_q <= acc_cnt_q + 32'd1;
            end
            if (!accept && (drop_cnt_q != 32'hFFFF_FFFF)) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    assign pkt_acc_cnt  = acc_cnt_q;
    assign pkt_drop_cnt = drop_cnt_q;
`endif
endmodule
